// File: rtl/riscv_demux_buf.sv
// -----------------------------------------------------------------------------
// riscv_demux_buf
//
// Routes one input word per cycle to one of N_DEMUX_OUT output lanes. Each
// lane owns a single registered slot (data + valid), so a word appears on its
// lane one cycle after it is accepted. Lanes drain independently of each
// other and of the input side.
//
// Handshake (applies to the input side and to every output lane): a word
// moves across an interface only at a rising edge where valid and ready are
// both 1. Ready never depends on the valid of the same interface, and a
// producer holds its data and select stable while valid=1 and ready=0.
//
// Ports
//   i_clk               : clock, all state changes on the rising edge
//   i_rstn              : asynchronous active-low reset
//   i_demux_data        : input word (`XLEN bits)
//   i_demux_sel         : destination lane index ($clog2(N) bits)
//   i_demux_valid       : input word and select are valid
//   o_demux_ready       : the input is accepted this cycle
//   o_demux_concat_data : lane data, lane i at [`XLEN*(i+1)-1 -: `XLEN]
//   o_demux_valid       : per-lane valid bits
//   i_demux_ready       : per-lane consumer ready bits
//   o_demux_drop        : one-cycle pulse after an out-of-range select is taken
// -----------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif

module riscv_demux_buf #(
    parameter int N_DEMUX_OUT = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic [`XLEN-1:0]                  i_demux_data,
    input  logic [$clog2(N_DEMUX_OUT)-1:0]    i_demux_sel,
    input  logic                              i_demux_valid,
    output logic                              o_demux_ready,
    output logic [N_DEMUX_OUT*`XLEN-1:0]      o_demux_concat_data,
    output logic [N_DEMUX_OUT-1:0]            o_demux_valid,
    input  logic [N_DEMUX_OUT-1:0]            i_demux_ready,
    output logic                              o_demux_drop
);

    localparam int XLEN  = `XLEN;
    localparam int N     = N_DEMUX_OUT;
    localparam int SEL_W = $clog2(N);

    // Lane count widened by one bit so the range check never overflows,
    // even when N is an exact power of two.
    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [XLEN-1:0] lane_data [N];
    logic [N-1:0]    lane_valid;
    logic [N-1:0]    lane_wr;

    logic sel_oob;
    logic sel_valid;
    logic sel_ready;
    logic xfer;
    logic drop_q;

    // A select at or beyond N only exists when N is not a power of two.
    assign sel_oob = ({1'b0, i_demux_sel} >= N_EXT);

    // Look up the addressed lane without indexing past the vector, so an
    // out-of-range select simply finds nothing and reads as "free".
    always_comb begin
        sel_valid = 1'b0;
        sel_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_demux_sel == SEL_W'(i)) begin
                sel_valid = lane_valid[i];
                sel_ready = i_demux_ready[i];
            end
        end
    end

    // The target slot can take a word if it is empty or is being emptied at
    // this same edge; out-of-range words are always taken and thrown away.
    assign o_demux_ready = sel_oob | ~sel_valid | sel_ready;
    assign xfer          = i_demux_valid & o_demux_ready;

    always_comb begin
        lane_wr = '0;
        for (int i = 0; i < N; i++) begin
            lane_wr[i] = xfer & ~sel_oob & (i_demux_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        // A write wins over a drain at the same edge: valid stays high and
        // the new word replaces the drained one without a bubble.
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                lane_valid[g] <= 1'b0;
                lane_data[g]  <= '0;
            end else if (lane_wr[g]) begin
                lane_valid[g] <= 1'b1;
                lane_data[g]  <= i_demux_data;
            end else if (lane_valid[g] && i_demux_ready[g]) begin
                // Data is left as-is so the last drained word stays visible.
                lane_valid[g] <= 1'b0;
            end
        end

        assign o_demux_concat_data[XLEN*(g+1)-1 -: XLEN] = lane_data[g];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= xfer & sel_oob;
        end
    end

    assign o_demux_valid = lane_valid;
    assign o_demux_drop  = drop_q;

endmodule

// File: tb/tb_riscv_demux_buf.sv
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_demux_buf;

    localparam int XW = `XLEN;

    // ---------------- clock / reset / shared stimulus ----------------
    logic          clk = 1'b0;
    logic          rstn;
    logic [XW-1:0] din;
    logic [1:0]    sel;
    logic          vin;
    logic [3:0]    rdy;

    always #5 clk = ~clk;

    // Two instances see the same input stream: N=4 (every select in range)
    // and N=3 (select 3 is the out-of-range case).
    logic            r4, drop4;
    logic [4*XW-1:0] cd4;
    logic [3:0]      v4;
    logic            r3, drop3;
    logic [3*XW-1:0] cd3;
    logic [2:0]      v3;

    riscv_demux_buf #(.N_DEMUX_OUT(4)) u_dut4 (
        .i_clk               (clk),
        .i_rstn              (rstn),
        .i_demux_data        (din),
        .i_demux_sel         (sel),
        .i_demux_valid       (vin),
        .o_demux_ready       (r4),
        .o_demux_concat_data (cd4),
        .o_demux_valid       (v4),
        .i_demux_ready       (rdy),
        .o_demux_drop        (drop4)
    );

    riscv_demux_buf #(.N_DEMUX_OUT(3)) u_dut3 (
        .i_clk               (clk),
        .i_rstn              (rstn),
        .i_demux_data        (din),
        .i_demux_sel         (sel),
        .i_demux_valid       (vin),
        .o_demux_ready       (r3),
        .o_demux_concat_data (cd3),
        .o_demux_valid       (v3),
        .i_demux_ready       (rdy[2:0]),
        .o_demux_drop        (drop3)
    );

    // ---------------- reference model ----------------
    // Index 0 models the N=4 instance, index 1 the N=3 instance. Each lane is
    // a one-word mailbox: full/empty flag plus the last word put into it.
    int            passed = 0;
    int            total  = 0;
    int            nl[2]  = '{4, 3};
    logic [XW-1:0] md[2][4];
    logic          mv[2][4];
    logic          mdrop[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mdrop[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                md[k][i] = '0;
                mv[k][i] = 1'b0;
            end
        end
    endtask

    // The mailbox can take a word when it is empty or its consumer is taking
    // the current one; words addressed past the last lane are always taken.
    function automatic logic model_ready(int k);
        if (int'(sel) >= nl[k]) return 1'b1;
        return !mv[k][sel] || rdy[sel];
    endfunction

    task automatic model_edge();
        logic acc;
        for (int k = 0; k < 2; k++) begin
            acc      = vin && model_ready(k);
            mdrop[k] = acc && (int'(sel) >= nl[k]);
            for (int i = 0; i < nl[k]; i++) begin
                if (acc && int'(sel) == i) begin
                    md[k][i] = din;
                    mv[k][i] = 1'b1;
                end else if (mv[k][i] && rdy[i]) begin
                    mv[k][i] = 1'b0;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_outputs(input string tag);
        logic [255:0] ed4, ed3, ev4, ev3;
        ed4 = '0; ed3 = '0; ev4 = '0; ev3 = '0;
        for (int i = 0; i < 4; i++) begin
            ed4[i*XW +: XW] = md[0][i];
            ev4[i]          = mv[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            ed3[i*XW +: XW] = md[1][i];
            ev3[i]          = mv[1][i];
        end
        chk({tag, "_data4"},  256'(cd4),   ed4);
        chk({tag, "_valid4"}, 256'(v4),    ev4);
        chk({tag, "_drop4"},  256'(drop4), 256'(mdrop[0]));
        chk({tag, "_data3"},  256'(cd3),   ed3);
        chk({tag, "_valid3"}, 256'(v3),    ev3);
        chk({tag, "_drop3"},  256'(drop3), 256'(mdrop[1]));
    endtask

    // ---------------- driver tasks ----------------
    // Drive inputs between edges, check ready before the edge, advance the
    // model at the edge, check registered outputs just after it.
    task automatic step(input logic v, input logic [1:0] s, input logic [XW-1:0] d,
                        input logic [3:0] r);
        vin = v; sel = s; din = d; rdy = r;
        #1;
        chk("ready4", 256'(r4), 256'(model_ready(0)));
        chk("ready3", 256'(r3), 256'(model_ready(1)));
        @(posedge clk);
        model_edge();
        #1;
        chk_outputs("step");
    endtask

    // Pulse reset low between edges, hold it across one edge with a word
    // offered, then release on the falling edge.
    task automatic do_reset();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_ready4", 256'(r4), 256'(1'b1));
        chk("rst_ready3", 256'(r3), 256'(1'b1));
        chk_outputs("rst_async");
        vin = 1'b1; sel = 2'($urandom_range(0, 3)); din = XW'($urandom);
        @(posedge clk);
        #1;
        chk_outputs("rst_hold");
        @(negedge clk);
        rstn = 1'b1;
        vin  = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rstn = 1'b0; vin = 1'b0; sel = '0; din = '0; rdy = '0;
        model_reset();
        #3;
        chk("init_ready4", 256'(r4), 256'(1'b1));
        chk_outputs("init");
        @(negedge clk);
        rstn = 1'b1;

        // Basic route, one-cycle latency, then drain.
        step(1'b1, 2'd2, XW'(32'hDEADBEEF), 4'b0000);
        chk("route_valid4", 256'(v4), 256'(4'b0100));
        chk("route_lane2",  256'(cd4[2*XW +: XW]), 256'(XW'(32'hDEADBEEF)));
        step(1'b0, 2'd0, '0, 4'b0100);
        chk("route_drained4", 256'(v4), 256'(4'b0000));

        // Backpressure on lane 1, then drain and refill on the same edge.
        step(1'b1, 2'd1, XW'(32'h11111111), 4'b0000);
        step(1'b1, 2'd1, XW'(32'h22222222), 4'b0000);
        chk("bp_hold_lane1", 256'(cd4[XW +: XW]), 256'(XW'(32'h11111111)));
        step(1'b1, 2'd1, XW'(32'h22222222), 4'b0010);
        chk("bp_swap_valid", 256'(v4[1]), 256'(1'b1));
        chk("bp_swap_lane1", 256'(cd4[XW +: XW]), 256'(XW'(32'h22222222)));
        step(1'b0, 2'd0, '0, 4'b1111);

        // Fill all lanes with consumers stalled; lane 3 on N=3 is a drop.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'(i), XW'(32'hA0A0_0000 + i), 4'b0000);
        end
        chk("par_valid4", 256'(v4), 256'(4'b1111));
        chk("par_valid3", 256'(v3), 256'(3'b111));
        chk("oob_drop3",  256'(drop3), 256'(1'b1));
        step(1'b0, 2'd0, '0, 4'b1010);
        chk("par_drain4", 256'(v4), 256'(4'b0101));
        chk("oob_drop3_clear", 256'(drop3), 256'(1'b0));

        // Lanes 0 and 3 (plus 2) full, then asynchronous reset mid-cycle.
        step(1'b1, 2'd3, XW'(32'h33333333), 4'b0000);
        do_reset();
        step(1'b1, 2'd3, XW'(32'h44444444), 4'b0000);
        chk("post_rst_valid4", 256'(v4), 256'(4'b1000));

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                     XW'($urandom), 4'($urandom_range(0, 15)));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
